// File: rtl/dmem_arbiter.sv
// Purpose: two-port arbiter/sequencer in front of a single-ported data memory, with access checking.
// Latency: memory access on the accepting edge; response registered and visible the following cycle.
// Backpressure: a port is only granted when its response slot is empty or being drained this cycle.
module dmem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_store,
    input  logic [2:0]        p0_req_funct3,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [31:0]       p0_req_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_store,
    input  logic [2:0]        p1_req_funct3,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [31:0]       p1_req_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,

    output logic [2:0]        mem_funct3,
    output logic              mem_load,
    output logic              mem_store,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Illegal funct3 for the access type, or a halfword/word not naturally aligned.
    function automatic logic access_err(input logic store, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        logic misaligned;
        if (store) begin
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        end
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return !legal || misaligned;
    endfunction

    logic        p0_rsp_valid_q, p0_rsp_valid_d;
    logic [31:0] p0_rsp_rdata_q, p0_rsp_rdata_d;
    logic        p0_rsp_err_q,   p0_rsp_err_d;
    logic        p1_rsp_valid_q, p1_rsp_valid_d;
    logic [31:0] p1_rsp_rdata_q, p1_rsp_rdata_d;
    logic        p1_rsp_err_q,   p1_rsp_err_d;
    logic        last_grant_q,   last_grant_d;

    logic p0_err, p1_err;
    logic p0_elig, p1_elig;
    logic gnt0, gnt1;

    assign p0_err  = access_err(p0_req_store, p0_req_funct3, p0_req_addr[1:0]);
    assign p1_err  = access_err(p1_req_store, p1_req_funct3, p1_req_addr[1:0]);

    // A port may issue only if its response slot will be free after this edge.
    assign p0_elig = p0_req_valid && (!p0_rsp_valid_q || p0_rsp_ready);
    assign p1_elig = p1_req_valid && (!p1_rsp_valid_q || p1_rsp_ready);

    // Grant selection: single eligible port wins outright; ties go by priority mode.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0_elig && p1_elig) begin
                if (FIXED_PRIO != 0) begin
                    gnt0 = 1'b1;
                end else if (last_grant_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = p0_elig;
                gnt1 = p1_elig;
            end
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    // Drive the memory from the granted port; faulting accesses never strobe load/store.
    always_comb begin
        mem_funct3 = 3'b000;
        mem_load   = 1'b0;
        mem_store  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        if (gnt0) begin
            mem_funct3 = p0_req_funct3;
            mem_addr   = p0_req_addr;
            mem_wdata  = p0_req_wdata;
            mem_load   = !p0_req_store && !p0_err;
            mem_store  = p0_req_store && !p0_err;
        end else if (gnt1) begin
            mem_funct3 = p1_req_funct3;
            mem_addr   = p1_req_addr;
            mem_wdata  = p1_req_wdata;
            mem_load   = !p1_req_store && !p1_err;
            mem_store  = p1_req_store && !p1_err;
        end
    end

    // Port 0 response slot: load on accept, drain on ready, otherwise hold.
    always_comb begin
        p0_rsp_valid_d = p0_rsp_valid_q;
        p0_rsp_rdata_d = p0_rsp_rdata_q;
        p0_rsp_err_d   = p0_rsp_err_q;
        if (gnt0) begin
            p0_rsp_valid_d = 1'b1;
            p0_rsp_rdata_d = mem_load ? mem_rdata : 32'd0;
            p0_rsp_err_d   = p0_err;
        end else if (p0_rsp_ready) begin
            p0_rsp_valid_d = 1'b0;
        end
    end

    // Port 1 response slot: same behaviour as port 0.
    always_comb begin
        p1_rsp_valid_d = p1_rsp_valid_q;
        p1_rsp_rdata_d = p1_rsp_rdata_q;
        p1_rsp_err_d   = p1_rsp_err_q;
        if (gnt1) begin
            p1_rsp_valid_d = 1'b1;
            p1_rsp_rdata_d = mem_load ? mem_rdata : 32'd0;
            p1_rsp_err_d   = p1_err;
        end else if (p1_rsp_ready) begin
            p1_rsp_valid_d = 1'b0;
        end
    end

    // Round-robin pointer moves only when an access is actually accepted.
    always_comb begin
        last_grant_d = last_grant_q;
        if ((FIXED_PRIO == 0) && (gnt0 || gnt1)) begin
            last_grant_d = gnt1;
        end
    end

    // State registers; reset drops any pending response and arms port 0 for the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rsp_valid_q <= 1'b0;
            p0_rsp_rdata_q <= 32'd0;
            p0_rsp_err_q   <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p1_rsp_rdata_q <= 32'd0;
            p1_rsp_err_q   <= 1'b0;
            last_grant_q   <= 1'b1;
        end else begin
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p0_rsp_rdata_q <= p0_rsp_rdata_d;
            p0_rsp_err_q   <= p0_rsp_err_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p1_rsp_rdata_q <= p1_rsp_rdata_d;
            p1_rsp_err_q   <= p1_rsp_err_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign p0_rsp_valid = p0_rsp_valid_q;
    assign p0_rsp_rdata = p0_rsp_rdata_q;
    assign p0_rsp_err   = p0_rsp_err_q;
    assign p1_rsp_valid = p1_rsp_valid_q;
    assign p1_rsp_rdata = p1_rsp_rdata_q;
    assign p1_rsp_err   = p1_rsp_err_q;

endmodule
